pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Next-PC controller that owns the enable and next-value inputs of the program counter register. Each cycle it picks the PC source: boot vector, sequential +4, branch/jump target, trap vector, or trap return. It also sequences pipeline flushes after redirects and handles halt/resume. It sits between the fetch/execute control logic and the PC register, and takes the register's current value back as i_PC.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded in the BOOT cycle after reset
TRAP_VECTOR, 32'h0000_0100, target for i_Trap and for misaligned redirects
FLUSH_CYCLES, 2, cycles o_Flush is held after a redirect (range 1..15)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset
i_PC  in  32  current PC register value
i_Stall  in  1  hold PC (pipeline back-pressure)
i_BranchTaken  in  1  branch/jump resolved taken this cycle
i_BranchTarget  in  32  branch/jump target
i_Trap  in  1  exception/interrupt request
i_TrapReturn  in  1  return from trap (mret)
i_EPC  in  32  return address for i_TrapReturn
i_Halt  in  1  debug halt request
i_Resume  in  1  debug resume request
o_PCEn  out  1  PC register enable (combinational)
o_NewPC  out  32  PC register next value (combinational)
o_Flush  out  1  squash in-flight fetch/decode (decoded from state)
o_Halted  out  1  high while in HALT
o_MisalignTrap  out  1  misaligned redirect converted to trap this cycle (combinational)
o_MisalignAddr  out  32  last offending target (registered)

Behaviour:
- Reset is i_Rst, synchronous, active-high; the clock is i_Clk. On reset: state=BOOT, flush counter=0, o_MisalignAddr=0. While i_Rst is high: o_PCEn=0, o_NewPC=RESET_VECTOR, o_Flush=0, o_Halted=0, o_MisalignTrap=0.
- States: BOOT, RUN, FLUSH, HALT.
- BOOT: o_PCEn=1, o_NewPC=RESET_VECTOR. Next state is FLUSH with counter=FLUSH_CYCLES. All inputs are ignored.
- RUN/FLUSH source priority (highest first):
  - Trap: o_PCEn=1, o_NewPC=TRAP_VECTOR.
  - TrapReturn: target=i_EPC.
  - BranchTaken (RUN only): target=i_BranchTarget. In FLUSH, branches are ignored because they come from squashed instructions.
  - Halt (RUN only): o_PCEn=0, next state HALT.
  - Stall: o_PCEn=0, o_NewPC=i_PC.
  - Otherwise: o_PCEn=1, o_NewPC=i_PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirects override i_Stall.
- Misalignment: if a TrapReturn or Branch target has bits [1:0]!=0:
  - o_NewPC=TRAP_VECTOR and o_MisalignTrap=1 that cycle.
  - o_MisalignAddr<=target at the next edge.
  - The misaligned target is never driven on o_NewPC.
- Any redirect (trap, return, branch, misalign) sets next state FLUSH with counter=FLUSH_CYCLES. A redirect while already in FLUSH reloads the counter.
- FLUSH: o_Flush=1. The counter decrements every cycle, stalled or not. When counter==1 and there is no redirect, next state is RUN. A Halt seen in FLUSH is not taken; the requester holds i_Halt until RUN.
- HALT: o_Halted=1, o_PCEn=0.
  - i_Trap: redirect to TRAP_VECTOR, go to FLUSH (o_Halted drops next cycle).
  - Otherwise i_Resume: next state RUN, o_PCEn=0 in the resume cycle.
  - i_Stall, i_BranchTaken and i_TrapReturn are ignored.
- Zero cycles from a redirect input to o_PCEn/o_NewPC. The PC register shows the target one edge later.
- Reset mid-FLUSH or mid-HALT takes effect at the next edge: state returns to BOOT, and there is no residual flush or halt.

Test Plan:
- Reset, then release: cycle 0 gives o_PCEn=1, o_NewPC=RESET_VECTOR; o_Flush=1 for 2 cycles; then o_NewPC=i_PC+4 each cycle (0x04, 0x08, ...).
- In RUN, i_PC=0x20, i_BranchTaken=1, target=0x80, i_Stall=1 -> o_PCEn=1, o_NewPC=0x80. o_Flush=1 for the next 2 cycles; a branch at target 0x44 during the flush is ignored.
- Same cycle i_Trap=1, i_BranchTaken=1 (target 0x80) -> o_NewPC=0x100. A second trap during the flush restarts a full 2-cycle flush.
- i_TrapReturn=1, i_EPC=0x1002 -> o_NewPC=0x100, o_MisalignTrap=1; o_MisalignAddr=0x1002 after the edge.
- i_PC=0xFFFF_FFFC, no events -> o_NewPC=0x0000_0000. i_Stall=1 -> o_PCEn=0.
- i_Halt in RUN -> o_Halted=1 next cycle, o_PCEn=0 for 10 cycles with i_Stall toggling. i_Resume -> RUN with o_PCEn=0 that cycle, then +4 resumes. Repeat with i_Trap while halted -> o_NewPC=0x100 and FLUSH.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects the program counter source each cycle (boot, +4,
// branch, trap, trap return), sequences post-redirect flushes and debug halt.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [31:0] i_PC,
   input  logic        i_Stall,
   input  logic        i_BranchTaken,
   input  logic [31:0] i_BranchTarget,
   input  logic        i_Trap,
   input  logic        i_TrapReturn,
   input  logic [31:0] i_EPC,
   input  logic        i_Halt,
   input  logic        i_Resume,
   output logic        o_PCEn,
   output logic [31:0] o_NewPC,
   output logic        o_Flush,
   output logic        o_Halted,
   output logic        o_MisalignTrap,
   output logic [31:0] o_MisalignAddr
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   function automatic logic f_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_flush_cnt;
   logic [3:0]  w_next_cnt;
   logic [31:0] r_MisalignAddr;
   logic        w_pc_en;
   logic [31:0] w_new_pc;
   logic        w_misalign;
   logic [31:0] w_misalign_addr;
   logic        w_redirect;
   logic        w_in_run;

   // Next-state, flush counter and PC source selection
   always_comb begin
      w_next_state    = r_state;
      w_next_cnt      = r_flush_cnt;
      w_pc_en         = 1'b0;
      w_new_pc        = i_PC;
      w_misalign      = 1'b0;
      w_misalign_addr = 32'h0000_0000;
      w_redirect      = 1'b0;
      w_in_run        = (r_state == S_RUN);

      case (r_state)
         S_BOOT: begin
            w_pc_en      = 1'b1;
            w_new_pc     = RESET_VECTOR;
            w_next_state = S_FLUSH;
            w_next_cnt   = FLUSH_LOAD;
         end
         S_RUN, S_FLUSH: begin
            if (i_Trap) begin
               w_pc_en    = 1'b1;
               w_new_pc   = TRAP_VECTOR;
               w_redirect = 1'b1;
            end else if (i_TrapReturn) begin
               w_pc_en    = 1'b1;
               w_redirect = 1'b1;
               if (f_misaligned(i_EPC)) begin
                  w_new_pc        = TRAP_VECTOR;
                  w_misalign      = 1'b1;
                  w_misalign_addr = i_EPC;
               end else begin
                  w_new_pc = i_EPC;
               end
            end else if (i_BranchTaken && w_in_run) begin
               w_pc_en    = 1'b1;
               w_redirect = 1'b1;
               if (f_misaligned(i_BranchTarget)) begin
                  w_new_pc        = TRAP_VECTOR;
                  w_misalign      = 1'b1;
                  w_misalign_addr = i_BranchTarget;
               end else begin
                  w_new_pc = i_BranchTarget;
               end
            end else if (i_Halt && w_in_run) begin
               w_pc_en      = 1'b0;
               w_next_state = S_HALT;
            end else if (i_Stall) begin
               w_pc_en  = 1'b0;
               w_new_pc = i_PC;
            end else begin
               w_pc_en  = 1'b1;
               w_new_pc = i_PC + 32'd4;
            end

            // A redirect always (re)starts a full flush window
            if (w_redirect) begin
               w_next_state = S_FLUSH;
               w_next_cnt   = FLUSH_LOAD;
            end else if (r_state == S_FLUSH) begin
               w_next_cnt = r_flush_cnt - 4'd1;
               if (r_flush_cnt <= 4'd1) begin
                  w_next_state = S_RUN;
               end else begin
                  w_next_state = S_FLUSH;
               end
            end else begin
               w_next_cnt = r_flush_cnt;
            end
         end
         S_HALT: begin
            if (i_Trap) begin
               w_pc_en      = 1'b1;
               w_new_pc     = TRAP_VECTOR;
               w_next_state = S_FLUSH;
               w_next_cnt   = FLUSH_LOAD;
            end else if (i_Resume) begin
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_HALT;
            end
         end
         default: begin
            w_next_state = S_BOOT;
            w_next_cnt   = 4'd0;
         end
      endcase
   end

   // State, flush counter and misaligned-target capture registers
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state        <= S_BOOT;
         r_flush_cnt    <= 4'd0;
         r_MisalignAddr <= 32'h0000_0000;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_next_cnt;
         if (w_misalign) begin
            r_MisalignAddr <= w_misalign_addr;
         end
      end
   end

   // Reset overrides every combinational output while it is asserted
   always_comb begin
      if (i_Rst) begin
         o_PCEn         = 1'b0;
         o_NewPC        = RESET_VECTOR;
         o_Flush        = 1'b0;
         o_Halted       = 1'b0;
         o_MisalignTrap = 1'b0;
      end else begin
         o_PCEn         = w_pc_en;
         o_NewPC        = w_new_pc;
         o_Flush        = (r_state == S_FLUSH);
         o_Halted       = (r_state == S_HALT);
         o_MisalignTrap = w_misalign;
      end
   end

   assign o_MisalignAddr = r_MisalignAddr;

endmodule
